// File: rtl/sipo_rx_if.sv
// Bus between the serial source / word consumer and the sipo_rx receiver.
// The receiver attaches through the slave modport; the driving side uses master.
interface sipo_rx_if #(
    parameter int WIDTH = 4
) ();
    logic             serial_in;
    logic             bit_en;
    logic             frame;
    logic             ready;
    logic [WIDTH-1:0] d_out;
    logic             valid;
    logic             overrun;
    logic             frame_err;
    logic             parity_err;
    logic             busy;

    modport slave (
        input  serial_in, bit_en, frame, ready,
        output d_out, valid, overrun, frame_err, parity_err, busy
    );

    modport master (
        output serial_in, bit_en, frame, ready,
        input  d_out, valid, overrun, frame_err, parity_err, busy
    );
endinterface

// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel word receiver with frame alignment and valid/ready output.
// Optional even-parity bit after each word is enabled by defining SIPO_PARITY_EN.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input logic     clk,
    input logic     rst,
    sipo_rx_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SIPO_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   d_out_q;
    logic               valid_q;
    logic               overrun_q;
    logic               frame_err_q;
    logic               parity_err_q;
    logic               busy_q;

    logic [WIDTH-1:0]   word_s;
    logic [WIDTH-1:0]   restart_word_s;
    logic               last_bit_s;
    logic               accept_s;
    logic               done_s;
    logic [WIDTH-1:0]   done_word_s;
    logic               done_perr_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    assign restart_word_s = {{(WIDTH-1){1'b0}}, bus.serial_in};
    assign last_bit_s     = (cnt_q == IDX_W'(WIDTH-1));
    assign accept_s       = !valid_q || bus.ready;

    // Current word with the incoming bit inserted, and whether this edge completes a word.
    always_comb begin
        word_s      = shift_q;
        done_s      = 1'b0;
        done_perr_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) == cnt_q) begin
                word_s[i] = bus.serial_in;
            end else begin
                word_s[i] = shift_q[i];
            end
        end
        done_word_s = word_s;
        if (bus.bit_en && !bus.frame) begin
            case (state_q)
                SHIFT: begin
`ifdef SIPO_PARITY_EN
                    done_s = 1'b0;
`else
                    done_s = last_bit_s;
`endif
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    done_s      = 1'b1;
                    done_word_s = shift_q;
                    done_perr_s = even_parity(shift_q) ^ bus.serial_in;
                end
`endif
                default: begin
                    done_s = 1'b0;
                end
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // Assembly FSM plus registered output/handshake state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            d_out_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // A new word wins over a same-edge consume; a blocked word is dropped.
            if (done_s && accept_s) begin
                d_out_q      <= done_word_s;
                parity_err_q <= done_perr_s;
                valid_q      <= 1'b1;
            end else if (done_s) begin
                overrun_q <= 1'b1;
            end else if (bus.ready) begin
                valid_q <= 1'b0;
            end

            if (bus.bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (bus.frame) begin
                            shift_q <= restart_word_s;
                            cnt_q   <= IDX_W'(1);
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (bus.frame) begin
                            frame_err_q <= 1'b1;
                            shift_q     <= restart_word_s;
                            cnt_q       <= IDX_W'(1);
                        end else if (last_bit_s) begin
`ifdef SIPO_PARITY_EN
                            shift_q <= word_s;
                            cnt_q   <= '0;
                            state_q <= PARITY;
`else
                            shift_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            shift_q <= word_s;
                            cnt_q   <= cnt_q + IDX_W'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        if (bus.frame) begin
                            frame_err_q <= 1'b1;
                            shift_q     <= restart_word_s;
                            cnt_q       <= IDX_W'(1);
                            state_q     <= SHIFT;
                        end else begin
                            shift_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.d_out      = d_out_q;
    assign bus.valid      = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: vector table for single words, scoreboard of
// expected delivered words, and hand-written sequences for multi-cycle corners.
module tb_sipo_rx;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(W)) bus ();
    sipo_rx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        logic         exp_perr;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b, input logic f);
        @(negedge clk);
        bus.bit_en    = 1'b1;
        bus.frame     = f;
        bus.serial_in = b;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.bit_en    = 1'b0;
        bus.frame     = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic pbit);
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], (i == 0));
        end
        if (PAR_ON) begin
            send_bit(pbit, 1'b0);
        end
    endtask

    // Scoreboard: every accepted word is compared against the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (rst === 1'b0 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got word %0h expected none at %0t", bus.d_out, $time);
            end else begin
                check("sb_data", bus.d_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{4'hB, 1'b1, 1'b0};
        vecs[1] = '{4'h0, 1'b0, 1'b0};
        vecs[2] = '{4'hF, 1'b0, 1'b0};
        vecs[3] = '{4'h5, 1'b0, 1'b0};
        vecs[4] = '{4'hA, 1'b0, 1'b0};
        vecs[5] = '{4'hB, 1'b0, 1'b1};

        rst = 1'b1;
        bus.serial_in = 1'b0;
        bus.bit_en    = 1'b0;
        bus.frame     = 1'b0;
        bus.ready     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_dout", bus.d_out, 4'h0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_parity_err", bus.parity_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        bus.ready = 1'b1;

        // Single words, ready held high
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].data);
            send_word(vecs[i].data, vecs[i].par);
            idle();
            check("vec_valid_lat", bus.valid, 1'b1);
            check("vec_dout", bus.d_out, vecs[i].data);
            check("vec_parity_err", bus.parity_err, vecs[i].exp_perr & PAR_ON);
            check("vec_busy_done", bus.busy, 1'b0);
            idle();
            check("vec_valid_clr", bus.valid, 1'b0);
        end

        // Backpressure and overrun
        bus.ready = 1'b0;
        exp_q.push_back(4'h3);
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b0);
        idle();
        check("ovr_valid", bus.valid, 1'b1);
        check("ovr_dout", bus.d_out, 4'h3);
        check("ovr_flag", bus.overrun, 1'b1);
        @(negedge clk);
        bus.ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_clr", bus.valid, 1'b0);
        check("ovr_dout_hold", bus.d_out, 4'h3);
        check("ovr_sticky", bus.overrun, 1'b1);

        // Asynchronous reset in the middle of a word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        idle();
        check("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", bus.d_out, 4'h0);
        check("mid_rst_valid", bus.valid, 1'b0);
        check("mid_rst_overrun", bus.overrun, 1'b0);
        check("mid_rst_frame_err", bus.frame_err, 1'b0);
        check("mid_rst_parity_err", bus.parity_err, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b1);
        idle();
        check("post_rst_valid", bus.valid, 1'b1);
        check("post_rst_dout", bus.d_out, 4'hB);
        idle();

        // Early frame on the third bit restarts the word at that bit
        exp_q.push_back(4'h6);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        check("ferr_pulse", bus.frame_err, 1'b1);
        send_bit(1'b1, 1'b0);
        check("ferr_clear", bus.frame_err, 1'b0);
        send_bit(1'b0, 1'b0);
        if (PAR_ON) send_bit(1'b0, 1'b0);
        idle();
        check("ferr_valid", bus.valid, 1'b1);
        check("ferr_dout", bus.d_out, 4'h6);
        idle();

        // Stall of five cycles between bits 2 and 3
        exp_q.push_back(4'hB);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("stall_busy", bus.busy, 1'b1);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        if (PAR_ON) send_bit(1'b1, 1'b0);
        idle();
        check("stall_valid", bus.valid, 1'b1);
        check("stall_dout", bus.d_out, 4'hB);
        check("stall_perr", bus.parity_err, 1'b0);
        idle();

        // Back-to-back words with no gap
        exp_q.push_back(4'h9);
        exp_q.push_back(4'h4);
        send_word(4'h9, 1'b0);
        send_word(4'h4, 1'b1);
        idle();
        check("b2b_valid", bus.valid, 1'b1);
        check("b2b_dout", bus.d_out, 4'h4);
        check("b2b_overrun", bus.overrun, 1'b0);
        idle();
        idle();
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
